// File: rtl/rv_trace_pkg.sv
// Shared types and widths for the commit-trace collector.
package rv_trace_pkg;

  localparam int TR_DATA_W = 32;
  localparam int TR_ADDR_W = 9;
  localparam int TR_TS_W   = 16;
  localparam int TR_DEPTH  = 16;
  localparam int DROP_W    = 16;

  typedef enum logic [1:0] {
    TR_REG   = 2'd0,
    TR_STORE = 2'd1,
    TR_LOAD  = 2'd2
  } trace_kind_e;

  typedef struct packed {
    trace_kind_e            kind;
    logic [TR_ADDR_W-1:0]   tag;
    logic [TR_DATA_W-1:0]   data;
    logic [TR_TS_W-1:0]     ts;
  } trace_entry_t;

endpackage

// File: rtl/rv_trace_collector_fifo.sv
// Trace FIFO with two write ports and one read port; accepts pushes in order
// while space (measured before this cycle's pop) allows.
module trace_fifo2w
  import rv_trace_pkg::*;
#(
  parameter int DEPTH = TR_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             push_req,
  input  trace_entry_t           wdata0,
  input  trace_entry_t           wdata1,
  output logic [1:0]             push_acc,
  input  logic                   pop_ready,
  output logic                   valid,
  output trace_entry_t           head,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  trace_entry_t mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr, wr_ptr1, free;
  logic         pop;

  // NOTE: combinational logic uses blocking '=' with every output assigned,
  // so no latch can be inferred; state below uses non-blocking '<='.
  always_comb begin
    level    = wr_ptr - rd_ptr;
    free     = (AW+1)'(DEPTH) - level;
    push_acc = ((AW+1)'(push_req) <= free) ? push_req : free[1:0];
    valid    = (level != '0);
    pop      = valid && pop_ready;
    wr_ptr1  = wr_ptr + 1'b1;
    head     = mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(push_acc);
      rd_ptr <= rd_ptr + (AW+1)'(pop);
    end
  end

  // NOTE: the storage array is not reset; the pointers alone say which slots hold live data.
  always_ff @(posedge clk) begin
    if (push_acc != 2'd0) mem[wr_ptr[AW-1:0]]  <= wdata0;
    if (push_acc == 2'd2) mem[wr_ptr1[AW-1:0]] <= wdata1;
  end

endmodule

// File: rtl/rv_trace_collector.sv
// Observe-only commit-trace collector: captures up to two events per cycle
// (WB register write, then MEM access), timestamps them and streams them out.
module rv_trace_collector
  import rv_trace_pkg::*;
#(
  parameter int DATA_W     = TR_DATA_W,
  parameter int DM_ADDRESS = TR_ADDR_W,
  parameter int DEPTH      = TR_DEPTH,
  parameter int TS_W       = TR_TS_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [4:0]             reg_num,
  input  logic [DATA_W-1:0]      reg_data,
  input  logic                   reg_write_sig,
  input  logic                   wr,
  input  logic                   reade,
  input  logic [DM_ADDRESS-1:0]  addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [DATA_W-1:0]      rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_kind,
  output logic [DM_ADDRESS-1:0]  out_tag,
  output logic [DATA_W-1:0]      out_data,
  output logic [TS_W-1:0]        out_ts,
  output logic [$clog2(DEPTH):0] level,
  output logic [DROP_W-1:0]      drop_cnt,
  output logic                   overflow
);

  logic [TS_W-1:0] ts;
  logic            reg_ev, st_ev, ld_ev, mem_ev;
  trace_entry_t    reg_entry, mem_entry, wdata0, head;
  logic [1:0]      push_req, push_acc, n_drop;
  logic [DROP_W:0] drop_sum;

  always_comb begin
    reg_ev    = enable && reg_write_sig && (reg_num != 5'd0);
    st_ev     = enable && wr;
    ld_ev     = enable && reade && !wr;
    mem_ev    = st_ev || ld_ev;
    reg_entry = '{kind: TR_REG, tag: DM_ADDRESS'(reg_num), data: reg_data, ts: ts};
    mem_entry = '{kind: st_ev ? TR_STORE : TR_LOAD, tag: addr,
                  data: st_ev ? wr_data : rd_data, ts: ts};
    // WB holds the older instruction, so the register event goes first.
    wdata0    = reg_ev ? reg_entry : mem_entry;
    push_req  = {1'b0, reg_ev} + {1'b0, mem_ev};
    n_drop    = push_req - push_acc;
    drop_sum  = {1'b0, drop_cnt} + (DROP_W+1)'(n_drop);
  end

  trace_fifo2w #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_req  (push_req),
    .wdata0    (wdata0),
    .wdata1    (mem_entry),
    .push_acc  (push_acc),
    .pop_ready (out_ready),
    .valid     (out_valid),
    .head      (head),
    .level     (level)
  );

  always_comb begin
    out_kind = head.kind;
    out_tag  = head.tag;
    out_data = head.data;
    out_ts   = head.ts;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ts       <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      ts <= ts + 1'b1;
      if (n_drop != 2'd0) overflow <= 1'b1;
      drop_cnt <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end
  end

endmodule

// File: tb/tb_rv_trace_collector.sv
// Directed bench for rv_trace_collector: expected entries are queued at issue
// time and a negedge monitor compares every accepted head against the queue.
module tb_rv_trace_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [4:0]  reg_num = '0;
  logic [31:0] reg_data = '0;
  logic        reg_write_sig = 1'b0;
  logic        wr = 1'b0;
  logic        reade = 1'b0;
  logic [8:0]  addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_kind;
  logic [8:0]  out_tag;
  logic [31:0] out_data;
  logic [15:0] out_ts;
  logic [4:0]  level;
  logic [15:0] drop_cnt;
  logic        overflow;

  typedef struct {
    logic [1:0]  kind;
    logic [8:0]  tag;
    logic [31:0] data;
    logic [15:0] ts;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] ts_m = '0;

  rv_trace_collector dut (
    .clk(clk), .reset(reset), .enable(enable), .reg_num(reg_num),
    .reg_data(reg_data), .reg_write_sig(reg_write_sig), .wr(wr), .reade(reade),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_kind(out_kind), .out_tag(out_tag),
    .out_data(out_data), .out_ts(out_ts), .level(level), .drop_cnt(drop_cnt),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference timestamp: cleared by reset, otherwise counts every cycle.
  always @(posedge clk) ts_m <= reset ? 16'd0 : ts_m + 16'd1;

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_entry: got kind=%0d tag=%h data=%h ts=%h, want none",
                 out_kind, out_tag, out_data, out_ts);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({out_kind, out_tag, out_data, out_ts} !== {e.kind, e.tag, e.data, e.ts}) begin
          n_bad++;
          $display("FAIL entry: got kind=%0d tag=%h data=%h ts=%h, want kind=%0d tag=%h data=%h ts=%h",
                   out_kind, out_tag, out_data, out_ts, e.kind, e.tag, e.data, e.ts);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Apply one cycle of core activity; the first n_acc generated events are expected out.
  task automatic step(input logic en, input logic rw, input logic [4:0] rn,
                      input logic [31:0] rv, input logic w, input logic r,
                      input logic [8:0] a, input logic [31:0] wd,
                      input logic [31:0] ld, input int n_acc);
    exp_t q[$];
    enable = en; reg_write_sig = rw; reg_num = rn; reg_data = rv;
    wr = w; reade = r; addr = a; wr_data = wd; rd_data = ld;
    if (en && rw && rn != 5'd0) q.push_back('{2'd0, {4'b0, rn}, rv, ts_m});
    if (en && w)      q.push_back('{2'd1, a, wd, ts_m});
    else if (en && r) q.push_back('{2'd2, a, ld, ts_m});
    for (int i = 0; i < n_acc && i < q.size(); i++) sb.push_back(q[i]);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    reg_write_sig = 1'b0; wr = 1'b0; reade = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_ts(input logic [15:0] t);
    int k = 0;
    while (ts_m != t && k < 70000) begin idle(1); k++; end
    if (ts_m != t) begin
      $display("FAIL ts_wait: got %h, want %h", ts_m, t);
      $fatal(1, "timestamp wait expired");
    end
  endtask

  task automatic drain(input int budget);
    int k = 0;
    out_ready = 1'b1;
    reg_write_sig = 1'b0; wr = 1'b0; reade = 1'b0;
    while ((level != 5'd0 || sb.size() != 0) && k < budget) begin
      @(posedge clk); #1; k++;
    end
    check("drain_level", {27'd0, level}, 32'd0);
    check("drain_left", sb.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_valid", {31'd0, out_valid}, 0);
    check("rst_level", {27'd0, level}, 0);
    check("rst_drop", {16'd0, drop_cnt}, 0);
    check("rst_ovf", {31'd0, overflow}, 0);

    // Single store at ts 5, consumer always ready.
    out_ready = 1'b1;
    wait_ts(16'd5);
    step(1, 0, 0, 0, 1, 0, 9'h010, 32'hDEADBEEF, 0, 1);
    check("st_valid", {31'd0, out_valid}, 1);
    check("st_level", {27'd0, level}, 1);
    idle(1);
    check("st_level0", {27'd0, level}, 0);

    // REG x7 and a LOAD in the same cycle: REG first, equal ts.
    step(1, 1, 5'd7, 32'h42, 0, 1, 9'h020, 0, 32'h11223344, 2);
    check("pair_level", {27'd0, level}, 2);
    idle(2);
    check("pair_level0", {27'd0, level}, 0);

    // x0 write and disabled capture produce nothing; store+load yields only a store.
    step(1, 1, 5'd0, 32'h55, 0, 0, 0, 0, 0, 0);
    step(0, 1, 5'd3, 32'h66, 1, 0, 9'h044, 32'h77, 0, 0);
    step(0, 0, 0, 0, 0, 1, 9'h048, 0, 32'h88, 0);
    check("none_level", {27'd0, level}, 0);
    step(1, 0, 0, 0, 1, 1, 9'h0AA, 32'hCAFE0001, 32'hBAD0BAD0, 1);
    idle(2);
    check("both_level0", {27'd0, level}, 0);

    // Stalled consumer, two events per cycle for 10 cycles.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++)
      step(1, 1, 5'(i + 1), 32'h1000 + i, i[0], !i[0], 9'(9'h100 + i),
           32'h2000 + i, 32'h3000 + i, (i < 8) ? 2 : 0);
    check("ovf_level", {27'd0, level}, 16);
    check("ovf_drop", {16'd0, drop_cnt}, 4);
    check("ovf_flag", {31'd0, overflow}, 1);
    check("stall_hold", out_data, sb[0].data);
    // Full with a simultaneous pop still drops both new events.
    out_ready = 1'b1;
    step(1, 1, 5'd20, 32'h4000, 1, 0, 9'h1F0, 32'h4001, 0, 0);
    check("full_pop_level", {27'd0, level}, 15);
    check("full_pop_drop", {16'd0, drop_cnt}, 6);
    drain(40);

    // level 15 with two events: REG kept, memory event dropped.
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++)
      step(1, 1, 5'(i + 8), 32'h5000 + i, 1, 0, 9'(9'h080 + i), 32'h6000 + i, 0, 2);
    step(1, 1, 5'd31, 32'h7000, 0, 0, 0, 0, 0, 1);
    check("l15_level", {27'd0, level}, 15);
    step(1, 1, 5'd30, 32'h7001, 0, 1, 9'h0C0, 0, 32'h7002, 1);
    check("l15_after", {27'd0, level}, 16);
    check("l15_drop", {16'd0, drop_cnt}, 7);
    drain(40);

    // Reset with 9 buffered entries; a store during reset is not captured.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      step(1, 1, 5'(i + 1), 32'h8000 + i, 0, 1, 9'(9'h0D0 + i), 0, 32'h9000 + i, 2);
    step(1, 0, 0, 0, 1, 0, 9'h0E0, 32'hA000, 0, 1);
    check("pre_rst_level", {27'd0, level}, 9);
    reset = 1'b1;
    sb.delete();
    step(1, 0, 0, 0, 1, 0, 9'h0E1, 32'hA001, 0, 0);
    reset = 1'b0;
    check("mid_rst_level", {27'd0, level}, 0);
    check("mid_rst_valid", {31'd0, out_valid}, 0);
    check("mid_rst_drop", {16'd0, drop_cnt}, 0);
    check("mid_rst_ovf", {31'd0, overflow}, 0);
    out_ready = 1'b1;
    step(1, 1, 5'd9, 32'hB000, 0, 0, 0, 0, 0, 1);
    idle(1);

    // Timestamp wrap: entries at 0xFFFF then 0x0000.
    wait_ts(16'hFFFF);
    step(1, 0, 0, 0, 1, 0, 9'h1FF, 32'hC000, 0, 1);
    step(1, 0, 0, 0, 0, 1, 9'h001, 0, 32'hC001, 1);
    drain(10);
    check("end_drop", {16'd0, drop_cnt}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
